// File: rtl/gf163_pkg.sv
// ---------------------------------------------------------------------------
// gf163_pkg
// Shared definitions for the GF(2^163) multiplier sharing logic.
//   M         : field width in bits
//   RED_POLY  : low byte of the reduction polynomial x^163 + x^7 + x^6 + x^3 + 1
//   state_t   : sequencing FSM states of gf_mult_arbiter
//   idx_width : width of a binary index over n items (at least 1 bit)
// ---------------------------------------------------------------------------
package gf163_pkg;

   localparam int M = 163;
   localparam logic [7:0] RED_POLY = 8'hC9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CLEAR = 2'b01,
      ST_RUN   = 2'b10,
      ST_RESP  = 2'b11
   } state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gf_mult_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after
// ptr, wrapping modulo N_REQ.
//   req       : request bits, one per requester
//   ptr       : highest-priority requester index for this pick
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : binary index of the granted requester (0 when no request)
// ---------------------------------------------------------------------------
module rr_arbiter
   import gf163_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IW    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    grant_idx
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      // NOTE: every variable gets a default before any branch; a path that
      // leaves one unassigned would turn it into a latch.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = IW'((int'(ptr) + k) % N_REQ);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/gf_mult_arbiter.sv
// ---------------------------------------------------------------------------
// gf_mult_arbiter
// Shares one external GF(2^163) interleaved multiplier between N_REQ
// requesters. A round-robin grant latches the winner's operands, the
// multiplier is cleared for one cycle, then started and held until done,
// and the product is returned to the owner as a one-cycle response. A
// watchdog aborts a hung operation with an error response.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester request
//   req_a/b    : operands, requester i at [i*M +: M]
//   req_ready  : one-hot accept pulse (combinational, in IDLE)
//   rsp_valid  : one-hot response pulse
//   rsp_data   : product, qualified by rsp_valid
//   rsp_err    : watchdog abort flag, qualified by rsp_valid
//   busy       : high whenever the FSM is not IDLE
//   mul_rst    : multiplier clear (also high throughout rst)
//   mul_start  : multiplier start, held for the whole run
//   mul_a/b    : registered multiplier operands
//   mul_z      : multiplier result, sampled only with mul_done
//   mul_done   : multiplier completion
// ---------------------------------------------------------------------------
module gf_mult_arbiter
   import gf163_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int M       = gf163_pkg::M,
   parameter int TIMEOUT = 200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*M-1:0] req_a,
   input  logic [N_REQ*M-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic [M-1:0]       rsp_data,
   output logic               rsp_err,
   output logic               busy,
   output logic               mul_rst,
   output logic               mul_start,
   output logic [M-1:0]       mul_a,
   output logic [M-1:0]       mul_b,
   input  logic [M-1:0]       mul_z,
   input  logic               mul_done
);

   localparam int IW = idx_width(N_REQ);
   localparam int WW = $clog2(TIMEOUT + 1);

   state_t         state;
   logic [IW-1:0]  ptr;
   logic [IW-1:0]  owner;
   logic [WW-1:0]  wdog;
   logic           mul_rst_q;

   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    grant_idx;
   logic [M-1:0]     sel_a;
   logic [M-1:0]     sel_b;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Operands of the requester the arbiter currently picks.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (i == int'(grant_idx)) begin
            sel_a = req_a[i*M +: M];
            sel_b = req_b[i*M +: M];
         end
      end
   end

   // The accept pulse must be visible in the same IDLE cycle the operands
   // are captured, so it is decoded from state rather than registered.
   assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;

   // The multiplier is held in clear for the full reset, not just after it.
   assign mul_rst = mul_rst_q | rst;

   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples values from before the edge, independent of order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         owner     <= '0;
         wdog      <= '0;
         mul_rst_q <= 1'b0;
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req_valid) begin
                  owner     <= grant_idx;
                  mul_a     <= sel_a;
                  mul_b     <= sel_b;
                  mul_rst_q <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_CLEAR;
               end
            end

            // The multiplier only re-arms after a clear, so this cycle is
            // never skipped.
            ST_CLEAR: begin
               mul_rst_q <= 1'b0;
               mul_start <= 1'b1;
               wdog      <= '0;
               state     <= ST_RUN;
            end

            ST_RUN: begin
               if (wdog != WW'(TIMEOUT)) begin
                  wdog <= wdog + 1'b1;
               end
               // Completion is checked first so a done that lands on the
               // last watchdog cycle still returns a good product.
               if (mul_done) begin
                  rsp_data  <= mul_z;
                  rsp_err   <= 1'b0;
                  rsp_valid <= N_REQ'(1) << owner;
                  mul_start <= 1'b0;
                  state     <= ST_RESP;
               end else if (wdog == WW'(TIMEOUT - 1)) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= N_REQ'(1) << owner;
                  mul_start <= 1'b0;
                  mul_rst_q <= 1'b1;    // abort the hung multiplier
                  state     <= ST_RESP;
               end
            end

            ST_RESP: begin
               rsp_valid <= '0;
               mul_rst_q <= 1'b0;
               busy      <= 1'b0;
               ptr       <= (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
               state     <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gf_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gf_mult_arbiter
// Drives gf_mult_arbiter with directed requests and a behavioural
// GF(2^163) multiplier of programmable latency. A timeline model predicts
// every output each cycle from the accept time of the current operation;
// literal products pin the model's field arithmetic.
// ---------------------------------------------------------------------------
module tb_gf_mult_arbiter;
   import gf163_pkg::*;

   localparam int N  = 4;
   localparam int MW = 163;
   localparam int TO = 200;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N*MW-1:0]   req_a = '0;
   logic [N*MW-1:0]   req_b = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      rsp_valid;
   logic [MW-1:0]     rsp_data;
   logic              rsp_err;
   logic              busy;
   logic              mul_rst;
   logic              mul_start;
   logic [MW-1:0]     mul_a;
   logic [MW-1:0]     mul_b;
   logic [MW-1:0]     mul_z;
   logic              mul_done = 1'b0;

   always #5 clk = ~clk;

   gf_mult_arbiter #(
      .N_REQ   (N),
      .M       (MW),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .mul_rst   (mul_rst),
      .mul_start (mul_start),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_z     (mul_z),
      .mul_done  (mul_done)
   );

   // ---------------- field arithmetic ----------------
   function automatic logic [MW-1:0] gf_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
      logic [MW-1:0] p;
      logic          c;
      p = '0;
      for (int i = MW - 1; i >= 0; i--) begin
         c = p[MW-1];
         p = p << 1;
         if (c) p[7:0] = p[7:0] ^ RED_POLY;
         if (b[i]) p = p ^ a;
      end
      return p;
   endfunction

   // ---------------- behavioural multiplier ----------------
   int            mul_lat  = 10;
   bit            mul_hang = 1'b0;
   int            mcnt     = 0;
   logic [MW-1:0] mprod    = '0;
   logic [MW-1:0] junk     = '0;

   always @(posedge clk) begin
      junk <= MW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      if (mul_rst) begin
         mcnt     <= 0;
         mul_done <= 1'b0;
      end else if (mul_start && !mul_done && !mul_hang) begin
         mcnt <= mcnt + 1;
         if (mcnt + 1 == mul_lat) begin
            mul_done <= 1'b1;
            mprod    <= gf_mul(mul_a, mul_b);
         end
      end
   end

   // Result bus carries garbage whenever done is low.
   assign mul_z = mul_done ? mprod : junk;

   // ---------------- checking ----------------
   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int            idx;
      logic [MW-1:0] data;
      logic          err;
   } rsp_t;

   int   grant_q[$];
   rsp_t rsp_q[$];

   // Timeline model: one operation at a time, described by its accept cycle
   // and the cycle its response is due.
   int            cyc      = 0;
   bit            have     = 1'b0;
   int            t0       = 0;
   int            t_resp   = 0;
   int            g        = 0;
   bit            t_err    = 1'b0;
   int            ptr      = 0;
   logic [MW-1:0] a_lat    = '0;
   logic [MW-1:0] b_lat    = '0;
   logic [MW-1:0] exp_z    = '0;
   bit            rst_prev = 1'b1;

   always @(negedge clk) begin : cmp
      logic [N-1:0] e_ready;
      logic [N-1:0] e_rv;
      logic         e_rst;
      logic         e_start;
      logic         e_busy;
      bit           idle;
      int           gi;
      int           idx;
      rsp_t         r;

      cyc++;
      idle    = !(have && cyc <= t_resp);
      e_ready = '0;
      gi      = -1;
      if (idle && !rst) begin
         for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (gi < 0 && req_valid[idx]) gi = idx;
         end
         if (gi >= 0) e_ready[gi] = 1'b1;
      end
      e_rv    = (have && cyc == t_resp) ? (N'(1) << g) : '0;
      e_busy  = have && cyc > t0 && cyc <= t_resp;
      e_rst   = rst || (have && (cyc == t0 + 1 || (t_err && cyc == t_resp)));
      e_start = have && cyc >= t0 + 2 && cyc < t_resp;

      check("req_ready", MW'(req_ready), MW'(e_ready));
      check("rsp_valid", MW'(rsp_valid), MW'(e_rv));
      check("busy",      MW'(busy),      MW'(e_busy));
      check("mul_rst",   MW'(mul_rst),   MW'(e_rst));
      check("mul_start", MW'(mul_start), MW'(e_start));
      check("mul_a",     mul_a,          a_lat);
      check("mul_b",     mul_b,          b_lat);
      if (e_rv != '0) begin
         check("rsp_data", rsp_data,      exp_z);
         check("rsp_err",  MW'(rsp_err),  MW'(t_err));
      end
      if (rst_prev) begin
         check("rst_rsp_data", rsp_data,     '0);
         check("rst_rsp_err",  MW'(rsp_err), '0);
      end

      for (int i = 0; i < N; i++) begin
         if (req_ready[i]) grant_q.push_back(i);
         if (rsp_valid[i]) begin
            r.idx  = i;
            r.data = rsp_data;
            r.err  = rsp_err;
            rsp_q.push_back(r);
         end
      end

      if (rst) begin
         have  = 1'b0;
         ptr   = 0;
         a_lat = '0;
         b_lat = '0;
      end else begin
         if (have && cyc == t_resp) ptr = (g + 1) % N;
         if (gi >= 0) begin
            have   = 1'b1;
            g      = gi;
            t0     = cyc;
            a_lat  = req_a[gi*MW +: MW];
            b_lat  = req_b[gi*MW +: MW];
            t_err  = mul_hang || (mul_lat > TO - 1);
            t_resp = t_err ? cyc + 2 + TO : cyc + 3 + mul_lat;
            exp_z  = t_err ? '0 : gf_mul(a_lat, b_lat);
         end
      end
      rst_prev = rst;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      tick(n);
      rst = 1'b0;
   endtask

   task automatic set_ops(input int i, input logic [MW-1:0] a, input logic [MW-1:0] b);
      req_a[i*MW +: MW] = a;
      req_b[i*MW +: MW] = b;
   endtask

   // Raise the masked requests and run until n_rsp responses are seen.
   // Without hold, each requester drops (and scrambles its operands) right
   // after its accept; with hold, requests stay up until the end.
   task automatic serve(input logic [N-1:0] mask, input bit hold, input int n_rsp, input int budget);
      int           got;
      int           c;
      logic [N-1:0] drop;
      got = 0;
      c   = 0;
      req_valid = req_valid | mask;
      while (got < n_rsp && c < budget) begin
         @(negedge clk);
         drop = hold ? '0 : (req_ready & req_valid);
         if (rsp_valid != '0) got++;
         @(posedge clk);
         #1;
         req_valid = req_valid & ~drop;
         for (int i = 0; i < N; i++) begin
            if (drop[i]) set_ops(i, MW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}), MW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}));
         end
         c++;
      end
      req_valid = '0;
      check("serve_rsp_count", MW'(got), MW'(n_rsp));
   endtask

   task automatic chk_rsp(input string name, input int k, input int idx, input logic [MW-1:0] data, input logic err);
      if (k < rsp_q.size()) begin
         check({name, "_idx"},  MW'(rsp_q[k].idx), MW'(idx));
         check({name, "_data"}, rsp_q[k].data,     data);
         check({name, "_err"},  MW'(rsp_q[k].err), MW'(err));
      end else begin
         check({name, "_present"}, MW'(rsp_q.size()), MW'(k + 1));
      end
   endtask

   task automatic chk_grant(input string name, input int k, input int idx);
      if (k < grant_q.size()) check(name, MW'(grant_q[k]), MW'(idx));
      else                    check({name, "_present"}, MW'(grant_q.size()), MW'(k + 1));
   endtask

   // ---------------- directed sequence ----------------
   initial begin : stim
      int            rb;
      int            gb;
      int            w;
      logic [MW-1:0] top_bit;
      top_bit = '0;
      top_bit[MW-1] = 1'b1;

      // Reset state
      tick(2);
      check("rst_mul_rst",   MW'(mul_rst),   MW'(1));
      check("rst_busy",      MW'(busy),      '0);
      check("rst_rsp_valid", MW'(rsp_valid), '0);
      check("rst_mul_a",     mul_a,          '0);
      tick(1);
      rst = 1'b0;

      // Single request from requester 1: 2*3 = 6
      mul_lat = 10;
      set_ops(1, MW'(2), MW'(3));
      rb = rsp_q.size();
      gb = grant_q.size();
      serve(4'b0010, 1'b0, 1, 100);
      chk_rsp("single", rb, 1, MW'(6), 1'b0);
      check("single_grants", MW'(grant_q.size() - gb), MW'(1));

      // Reduction: x^162 * x = 0xC9
      set_ops(0, top_bit, MW'(2));
      rb = rsp_q.size();
      serve(4'b0001, 1'b0, 1, 100);
      chk_rsp("reduce", rb, 0, MW'(8'hC9), 1'b0);

      // Simultaneous 0 and 2 from reset: 5*7 = 0x1B, 4*4 = 0x10
      do_reset(2);
      set_ops(0, MW'(5), MW'(7));
      set_ops(2, MW'(4), MW'(4));
      rb = rsp_q.size();
      gb = grant_q.size();
      serve(4'b0101, 1'b0, 2, 100);
      chk_grant("pair_g0", gb, 0);
      chk_grant("pair_g1", gb + 1, 2);
      chk_rsp("pair_r0", rb, 0, MW'(8'h1B), 1'b0);
      chk_rsp("pair_r1", rb + 1, 2, MW'(8'h10), 1'b0);

      // All four held: order 0,1,2,3,0; products (i+2)*3
      do_reset(2);
      for (int i = 0; i < N; i++) set_ops(i, MW'(i + 2), MW'(3));
      rb = rsp_q.size();
      gb = grant_q.size();
      serve(4'b1111, 1'b1, 5, 200);
      chk_grant("all_g0", gb,     0);
      chk_grant("all_g1", gb + 1, 1);
      chk_grant("all_g2", gb + 2, 2);
      chk_grant("all_g3", gb + 3, 3);
      chk_grant("all_g4", gb + 4, 0);
      chk_rsp("all_r1", rb + 1, 1, MW'(8'h05), 1'b0);
      chk_rsp("all_r2", rb + 2, 2, MW'(8'h0C), 1'b0);
      chk_rsp("all_r3", rb + 3, 3, MW'(8'h0F), 1'b0);

      // Back-to-back from requester 3: 6 then 5
      rb = rsp_q.size();
      set_ops(3, MW'(2), MW'(3));
      serve(4'b1000, 1'b0, 1, 100);
      set_ops(3, MW'(3), MW'(3));
      serve(4'b1000, 1'b0, 1, 100);
      chk_rsp("b2b_r0", rb,     3, MW'(6), 1'b0);
      chk_rsp("b2b_r1", rb + 1, 3, MW'(5), 1'b0);

      // Request withdrawn before grant while busy has no effect
      mul_lat = 30;
      gb = grant_q.size();
      set_ops(1, MW'(2), MW'(3));
      req_valid = 4'b0010;
      tick(1);
      req_valid = 4'b0100;
      tick(5);
      req_valid = '0;
      serve(4'b0000, 1'b0, 1, 100);
      check("withdraw_grants", MW'(grant_q.size() - gb), MW'(1));
      chk_grant("withdraw_g", gb, 1);

      // Done on the last watchdog cycle still wins
      mul_lat = TO - 1;
      rb = rsp_q.size();
      set_ops(2, MW'(2), MW'(3));
      serve(4'b0100, 1'b0, 1, TO + 20);
      chk_rsp("edge_done", rb, 2, MW'(6), 1'b0);

      // Hung multiplier: error response, then normal service resumes
      mul_hang = 1'b1;
      rb = rsp_q.size();
      set_ops(0, MW'(3), MW'(3));
      serve(4'b0001, 1'b0, 1, TO + 20);
      chk_rsp("timeout", rb, 0, '0, 1'b1);
      mul_hang = 1'b0;
      mul_lat  = 10;
      set_ops(1, MW'(2), MW'(3));
      serve(4'b0010, 1'b0, 1, 100);
      chk_rsp("after_timeout", rb + 1, 1, MW'(6), 1'b0);

      // Reset 50 cycles into RUN: no response, then a fresh request works
      mul_hang = 1'b1;
      rb = rsp_q.size();
      set_ops(3, MW'(2), MW'(2));
      req_valid = 4'b1000;
      tick(1);
      req_valid = '0;
      w = 0;
      while (!mul_start && w < 10) begin
         tick(1);
         w++;
      end
      check("midrst_started", MW'(mul_start), MW'(1));
      tick(49);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      check("midrst_no_rsp", MW'(rsp_q.size() - rb), '0);
      mul_hang = 1'b0;
      set_ops(3, MW'(2), MW'(3));
      serve(4'b1000, 1'b0, 1, 100);
      chk_rsp("midrst_fresh", rb, 3, MW'(6), 1'b0);

      tick(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin : guard
      #2000000;
      $display("FAIL global_time_limit: got no finish expected finish");
      $fatal(1);
   end

endmodule
